// File: rtl/x1_sad_pkg.sv
// Shared widths, batch-mode encodings and the running-minimum seed for the
// X1 SAD minimum search.
package x1_sad_pkg;

   localparam int SAD_W_DEF   = 32;
   localparam int NUM_SAD_DEF = 16;
   localparam int BATCH_W_DEF = 12;

   localparam logic [1:0] SAD_MODE_MID    = 2'b00;
   localparam logic [1:0] SAD_MODE_FIRST  = 2'b01;
   localparam logic [1:0] SAD_MODE_LAST   = 2'b10;
   localparam logic [1:0] SAD_MODE_SINGLE = 2'b11;

   // Wide enough for any SAD_W up to 64; truncation keeps it all-ones.
   localparam logic [63:0] SAD_MIN_INIT = '1;

endpackage

// File: rtl/x1_sad_min_tracker_min4.sv
// Four-input unsigned minimum with 2-bit position; ties resolve to the
// lowest position so earlier lanes win.
module sad_min4 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] a2,
   input  logic [W-1:0] a3,
   output logic [W-1:0] min_val,
   output logic [1:0]   min_idx
);

   logic [W-1:0] m01;
   logic [W-1:0] m23;
   logic         s01;
   logic         s23;
   logic         sf;

   // Only a strictly smaller right-hand operand may displace the left one.
   assign s01     = (a1 < a0);
   assign m01     = s01 ? a1 : a0;
   assign s23     = (a3 < a2);
   assign m23     = s23 ? a3 : a2;
   assign sf      = (m23 < m01);
   assign min_val = sf ? m23 : m01;
   assign min_idx = sf ? {1'b1, s23} : {1'b0, s01};

endmodule

// File: rtl/x1_sad_min_tracker.sv
// X1-stage SAD minimum tracker: 16->4 reduction at S1, 4->1 plus running-min
// update and writeback commit at S2, with batch counting and hazard hold.
module x1_sad_min_tracker
   import x1_sad_pkg::*;
#(
   parameter int SAD_W   = SAD_W_DEF,
   parameter int NUM_SAD = NUM_SAD_DEF,
   parameter int BATCH_W = BATCH_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [SAD_W-1:0]   X1_sadMem0_out,
   input  logic [SAD_W-1:0]   X1_sadMem1_out,
   input  logic [SAD_W-1:0]   X1_sadMem2_out,
   input  logic [SAD_W-1:0]   X1_sadMem3_out,
   input  logic [SAD_W-1:0]   X1_sadMem4_out,
   input  logic [SAD_W-1:0]   X1_sadMem5_out,
   input  logic [SAD_W-1:0]   X1_sadMem6_out,
   input  logic [SAD_W-1:0]   X1_sadMem7_out,
   input  logic [SAD_W-1:0]   X1_sadMem8_out,
   input  logic [SAD_W-1:0]   X1_sadMem9_out,
   input  logic [SAD_W-1:0]   X1_sadMem10_out,
   input  logic [SAD_W-1:0]   X1_sadMem11_out,
   input  logic [SAD_W-1:0]   X1_sadMem12_out,
   input  logic [SAD_W-1:0]   X1_sadMem13_out,
   input  logic [SAD_W-1:0]   X1_sadMem14_out,
   input  logic [SAD_W-1:0]   X1_sadMem15_out,
   input  logic               X1_minRegWrite,
   input  logic [1:0]         X1_sadRegWrite,
   input  logic [4:0]         X1_WriteRegCarry,
   input  logic               Hold,
   output logic [SAD_W-1:0]   WB_MinValue,
   output logic [BATCH_W+3:0] WB_MinIndex,
   output logic [4:0]         WB_MinDest,
   output logic               WB_MinWrite,
   output logic               Busy
);

   localparam int NGRP  = NUM_SAD / 4;
   localparam int IDX_W = BATCH_W + 4;

   logic [SAD_W-1:0]   lane_p0 [NUM_SAD];
   logic [SAD_W-1:0]   pmin_p0 [NGRP];
   logic [1:0]         pidx_p0 [NGRP];
   logic               first_p0;
   logic               last_p0;
   logic [BATCH_W-1:0] bnum_p0;

   logic               srch_act;
   logic [BATCH_W-1:0] bcnt;

   logic               vld_p1;
   logic               first_p1;
   logic               last_p1;
   logic [SAD_W-1:0]   pmin_p1 [NGRP];
   logic [1:0]         pidx_p1 [NGRP];
   logic [4:0]         dest_p1;
   logic [BATCH_W-1:0] bnum_p1;

   logic [SAD_W-1:0]   bmin_p1;
   logic [1:0]         bsel_p1;
   logic [IDX_W-1:0]   bidx_p1;
   logic               upd_p1;
   logic [SAD_W-1:0]   nmin_p1;
   logic [IDX_W-1:0]   nidx_p1;

   logic [SAD_W-1:0]   run_min;
   logic [IDX_W-1:0]   run_idx;

   assign lane_p0[0]  = X1_sadMem0_out;
   assign lane_p0[1]  = X1_sadMem1_out;
   assign lane_p0[2]  = X1_sadMem2_out;
   assign lane_p0[3]  = X1_sadMem3_out;
   assign lane_p0[4]  = X1_sadMem4_out;
   assign lane_p0[5]  = X1_sadMem5_out;
   assign lane_p0[6]  = X1_sadMem6_out;
   assign lane_p0[7]  = X1_sadMem7_out;
   assign lane_p0[8]  = X1_sadMem8_out;
   assign lane_p0[9]  = X1_sadMem9_out;
   assign lane_p0[10] = X1_sadMem10_out;
   assign lane_p0[11] = X1_sadMem11_out;
   assign lane_p0[12] = X1_sadMem12_out;
   assign lane_p0[13] = X1_sadMem13_out;
   assign lane_p0[14] = X1_sadMem14_out;
   assign lane_p0[15] = X1_sadMem15_out;

   // ---- S0 -> S1: per-group reduction, mode decode, batch numbering ----
   // A middle/last batch arriving with no search open starts one implicitly.
   assign first_p0 = (X1_sadRegWrite == SAD_MODE_FIRST)  ||
                     (X1_sadRegWrite == SAD_MODE_SINGLE) || !srch_act;
   assign last_p0  = (X1_sadRegWrite == SAD_MODE_LAST)   ||
                     (X1_sadRegWrite == SAD_MODE_SINGLE);
   assign bnum_p0  = first_p0 ? '0 : bcnt + 1'b1;

   for (genvar g = 0; g < NGRP; g++) begin : g_s1
      sad_min4 #(.W(SAD_W)) u_min4 (
         .a0      (lane_p0[4*g]),
         .a1      (lane_p0[4*g+1]),
         .a2      (lane_p0[4*g+2]),
         .a3      (lane_p0[4*g+3]),
         .min_val (pmin_p0[g]),
         .min_idx (pidx_p0[g])
      );
   end

   always_ff @(posedge Clk) begin
      if (!Hold && X1_minRegWrite) begin
         pmin_p1 <= pmin_p0;
         pidx_p1 <= pidx_p0;
         dest_p1 <= X1_WriteRegCarry;
         bnum_p1 <= bnum_p0;
      end
   end

   // ---- S1 -> S2: final reduction, running-min update, commit ----
   sad_min4 #(.W(SAD_W)) u_min4_s2 (
      .a0      (pmin_p1[0]),
      .a1      (pmin_p1[1]),
      .a2      (pmin_p1[2]),
      .a3      (pmin_p1[3]),
      .min_val (bmin_p1),
      .min_idx (bsel_p1)
   );

   assign bidx_p1 = {bnum_p1, bsel_p1, pidx_p1[bsel_p1]};
   // Strict compare keeps the earlier batch on a tie.
   assign upd_p1  = first_p1 || (bmin_p1 < run_min);
   assign nmin_p1 = upd_p1 ? bmin_p1 : run_min;
   assign nidx_p1 = upd_p1 ? bidx_p1 : run_idx;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vld_p1      <= 1'b0;
         first_p1    <= 1'b0;
         last_p1     <= 1'b0;
         srch_act    <= 1'b0;
         bcnt        <= '0;
         run_min     <= SAD_W'(SAD_MIN_INIT);
         run_idx     <= '0;
         WB_MinValue <= '0;
         WB_MinIndex <= '0;
         WB_MinDest  <= '0;
         WB_MinWrite <= 1'b0;
         Busy        <= 1'b0;
      end else if (Hold) begin
         WB_MinWrite <= 1'b0;
      end else begin
         vld_p1 <= X1_minRegWrite;
         if (X1_minRegWrite) begin
            first_p1 <= first_p0;
            last_p1  <= last_p0;
            srch_act <= !last_p0;
            bcnt     <= bnum_p0;
         end
         if (vld_p1) begin
            run_min <= nmin_p1;
            run_idx <= nidx_p1;
         end
         WB_MinWrite <= vld_p1 && last_p1;
         if (vld_p1 && last_p1) begin
            WB_MinValue <= nmin_p1;
            WB_MinIndex <= nidx_p1;
            WB_MinDest  <= dest_p1;
         end
         // A new search opening on the same edge as a commit keeps Busy high.
         if (X1_minRegWrite && first_p0) begin
            Busy <= 1'b1;
         end else if (vld_p1 && last_p1) begin
            Busy <= 1'b0;
         end
      end
   end

endmodule
